// File: rtl/pipe_stage_skid_buffer_if.sv
// Handshake bundle between the fetch stage and the IF/ID pipeline register.
// master = fetch/decode side that drives the stage inputs.
// slave  = the pipeline register itself.
interface pipe_stage_skid_buffer_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int FCNT_W  = 8
);
    logic               inValid;
    logic               inReady;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    updatedPC;
    logic               flush;
    logic               stall;
    logic               outValid;
    logic               outReady;
    logic [INSTR_W-1:0] instructionOut;
    logic [PC_W-1:0]    updatedPCOut;
    logic [FCNT_W-1:0]  flushCount;

    modport master (
        output inValid, instruction, updatedPC, flush, stall, outReady,
        input  inReady, outValid, instructionOut, updatedPCOut, flushCount
    );

    modport slave (
        input  inValid, instruction, updatedPC, flush, stall, outReady,
        output inReady, outValid, instructionOut, updatedPCOut, flushCount
    );
endinterface

// File: rtl/pipe_stage_skid_buffer.sv
// IF/ID pipeline register with valid/ready handshake.
// SKID=1: main register plus one skid entry, registered inReady, full throughput.
// SKID=0: single register, inReady looks through to the downstream side.
// flush empties the stage, forces the head to NOP_INSTR / PC 0 and bumps a
// saturating flush counter; stall only masks outValid.
module pipe_stage_skid_buffer #(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter int                 SKID      = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
    parameter int                 FCNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipe_stage_skid_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               in_ready_q, in_ready_d;

    logic               main_valid_s;
    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        logic [FCNT_W-1:0] r;
        if (v == {FCNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + FCNT_W'(1);
        end
        return r;
    endfunction

    assign main_valid_s = (state_q != ST_EMPTY);
    assign pop_s        = main_valid_s && !bus.stall && bus.outReady;
    assign push_s       = bus.inValid && in_ready_s;

    // inReady source: registered "not full" with a skid, look-through without one.
    always_comb begin
        in_ready_s = 1'b0;
        if (SKID != 0) begin
            in_ready_s = in_ready_q;
        end else begin
            in_ready_s = !main_valid_s || (bus.outReady && !bus.stall);
        end
    end

    // Next-state and next-data: flush wins, otherwise move words per occupancy.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        fcnt_d       = fcnt_q;
        if (bus.flush) begin
            // Any same-cycle pop has already been taken by decode; the input word is dropped.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = {PC_W{1'b0}};
            skid_instr_d = {INSTR_W{1'b0}};
            skid_pc_d    = {PC_W{1'b0}};
            fcnt_d       = sat_inc(fcnt_q);
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d      = ST_ONE;
                        main_instr_d = bus.instruction;
                        main_pc_d    = bus.updatedPC;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        main_instr_d = bus.instruction;
                        main_pc_d    = bus.updatedPC;
                    end else if (push_s && (SKID != 0)) begin
                        // Head still waiting: park the new word behind it.
                        state_d      = ST_TWO;
                        skid_instr_d = bus.instruction;
                        skid_pc_d    = bus.updatedPC;
                    end else if (pop_s) begin
                        // Outputs keep showing the delivered word.
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready_d = (state_d != ST_TWO);

    // State, storage, counter and registered inReady update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= {PC_W{1'b0}};
            skid_instr_q <= {INSTR_W{1'b0}};
            skid_pc_q    <= {PC_W{1'b0}};
            fcnt_q       <= {FCNT_W{1'b0}};
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            fcnt_q       <= fcnt_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.inReady        = in_ready_s;
    assign bus.outValid       = main_valid_s && !bus.stall;
    assign bus.instructionOut = main_instr_q;
    assign bus.updatedPCOut   = main_pc_q;
    assign bus.flushCount     = fcnt_q;

endmodule
